// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and helpers for the byte-lane data memory.
//   SZ_B/SZ_H/SZ_W   request size encodings (2'b11 is illegal)
//   OFF_GPIO_*       byte offsets inside the memory-mapped I/O window
//   rsp_kind_e       what the held response slot returns as read data
//   load_extract     picks a byte/half out of a word and sign/zero-extends it
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [7:0] OFF_GPIO_IN  = 8'h00;
  localparam logic [7:0] OFF_GPIO_OUT = 8'h04;

  typedef enum logic [1:0] {
    RkNone,  // store or fault: read data is zero
    RkRam,   // load served from the RAM read register
    RkMmio   // load served from the captured MMIO value
  } rsp_kind_e;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    b = shifted[7:0];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    load_extract = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    load_extract = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// dmem_lane_ram: DEPTH x 32 RAM with per-byte write enables and a registered read.
//   clk    clock
//   we     per-lane write enable (lane i = bits [8i+7:8i])
//   re     read enable; rdata updates only when set, otherwise holds
//   addr   word index
//   wdata  write data, already replicated onto the lanes
//   rdata  registered read data
// Contents are not reset.
module dmem_lane_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-addressed data memory for the MEM stage.
// Handles LB/LH/LW/LBU/LHU/SB/SH/SW with a valid/ready request, a one-entry
// response slot with back-pressure, and fault detection (misaligned, out of
// range, illegal size). Define DMEM_MMIO_EN to decode a GPIO window at MMIO_BASE.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_we/size/unsigned/addr/wdata  request fields
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata, rsp_fault         response payload
//   fault_sticky                 set by any faulting access, cleared by rst
//   gpio_in, gpio_out            board I/O (only live with DMEM_MMIO_EN)
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned IN_W      = 11,
  parameter int unsigned OUT_W     = 21,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_fault,
  output logic             fault_sticky,
  input  logic [IN_W-1:0]  gpio_in,
  output logic [OUT_W-1:0] gpio_out
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic        is_mmio;
  logic        fault;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;
  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic [31:0] mmio_rdata;

  logic        rsp_valid_q;
  logic        rsp_fault_q;
  rsp_kind_e   rsp_kind_q;
  logic [1:0]  rsp_off_q;
  logic [1:0]  rsp_size_q;
  logic        rsp_uns_q;
  logic [31:0] rsp_mmio_q;
  logic        fault_sticky_q;

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Decode and fault classification
  always_comb begin
    misaligned   = 1'b0;
    lane_mask    = 4'b0000;
    lane_wdata   = req_wdata;
    case (req_size)
      SZ_B: begin
        lane_mask  = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        misaligned = req_addr[0];
        lane_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      SZ_W: begin
        misaligned = (req_addr[1:0] != 2'b00);
        lane_mask  = 4'b1111;
      end
      default: misaligned = 1'b1;  // illegal size
    endcase
    out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
`ifdef DMEM_MMIO_EN
    is_mmio = (req_addr[31:8] == MMIO_BASE[31:8]);
    if (is_mmio) begin
      fault = misaligned || (req_size != SZ_W) ||
              ((req_addr[7:0] != OFF_GPIO_IN) && (req_addr[7:0] != OFF_GPIO_OUT));
    end else begin
      fault = misaligned || out_of_range;
    end
`else
    is_mmio = 1'b0;
    fault   = misaligned || out_of_range;
`endif
  end

  assign ram_we = (accept && req_we && !fault && !is_mmio) ? lane_mask : 4'b0000;
  assign ram_re = accept && !req_we && !fault && !is_mmio;

  dmem_lane_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (req_addr[AW+1:2]),
    .wdata (lane_wdata),
    .rdata (ram_rdata)
  );

`ifdef DMEM_MMIO_EN
  logic [IN_W-1:0]  gpio_in_q;
  logic [OUT_W-1:0] gpio_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_in_q  <= '0;
      gpio_out_q <= '0;
    end else begin
      gpio_in_q <= gpio_in;
      if (accept && req_we && !fault && is_mmio && (req_addr[7:0] == OFF_GPIO_OUT)) begin
        gpio_out_q <= req_wdata[OUT_W-1:0];
      end
    end
  end

  assign gpio_out   = gpio_out_q;
  assign mmio_rdata = (req_addr[7:0] == OFF_GPIO_OUT) ? 32'(gpio_out_q) : 32'(gpio_in_q);
`else
  logic unused_gpio_in;
  assign unused_gpio_in = ^gpio_in;
  assign gpio_out       = '0;
  assign mmio_rdata     = '0;
`endif

  // Response slot; read data is rebuilt from the held RAM register so it stays
  // stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q    <= 1'b0;
      rsp_fault_q    <= 1'b0;
      rsp_kind_q     <= RkNone;
      rsp_off_q      <= 2'b00;
      rsp_size_q     <= SZ_B;
      rsp_uns_q      <= 1'b0;
      rsp_mmio_q     <= '0;
      fault_sticky_q <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_fault_q <= fault;
      rsp_off_q   <= req_addr[1:0];
      rsp_size_q  <= req_size;
      rsp_uns_q   <= req_unsigned;
      rsp_mmio_q  <= mmio_rdata;
      if (fault || req_we) rsp_kind_q <= RkNone;
      else if (is_mmio)    rsp_kind_q <= RkMmio;
      else                 rsp_kind_q <= RkRam;
      if (fault) fault_sticky_q <= 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  always_comb begin
    rsp_rdata = '0;
    unique case (rsp_kind_q)
      RkRam:   rsp_rdata = load_extract(ram_rdata, rsp_off_q, rsp_size_q, rsp_uns_q);
      RkMmio:  rsp_rdata = rsp_mmio_q;
      default: rsp_rdata = '0;
    endcase
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_fault    = rsp_fault_q;
  assign fault_sticky = fault_sticky_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench for dmem_bytelane. Define DMEM_MMIO_EN for both RTL and bench
// to cover the GPIO window.
module tb_dmem_bytelane;

  localparam int unsigned IN_W  = 11;
  localparam int unsigned OUT_W = 21;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_rdata;
  logic             rsp_fault;
  logic             fault_sticky;
  logic [IN_W-1:0]  gpio_in;
  logic [OUT_W-1:0] gpio_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_bytelane #(
    .DEPTH     (256),
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .MMIO_BASE (32'hFFFF_FF00)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault),
    .fault_sticky (fault_sticky),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out)
  );

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // One request with rsp_ready high; returns the response seen one cycle later.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic fault);
    int waited;
    @(negedge clk);
    drive(we, size, uns, addr, wdata);
    waited = 0;
    #1;
    while (!req_ready && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: req_ready=%0b required 1 (addr %h)", req_ready, addr);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rdata = rsp_rdata;
    fault = rsp_fault;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rsp: valid=%b rdata=%h fault=%b required 0/0/0",
               rsp_valid, rsp_rdata, rsp_fault);
    end
    vectors++;
    if (fault_sticky !== 1'b0 || gpio_out !== '0) begin
      miscompares++;
      $display("FAIL reset_state: sticky=%b gpio_out=%h required 0/0", fault_sticky, gpio_out);
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_word_byte();
    logic [31:0] d;
    logic f;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, d, f);
    vectors++;
    if (d !== 32'h0 || f !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_rsp: rdata=%h fault=%b required 00000000/0", d, f);
    end
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, d, f);
    vectors++;
    if (d !== 32'h0000_0033 || f !== 1'b0) begin
      miscompares++;
      $display("FAIL lb_11: rdata=%h fault=%b required 00000033/0", d, f);
    end
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, d, f);
    vectors++;
    if (d !== 32'h0000_0011) begin
      miscompares++;
      $display("FAIL lbu_13: rdata=%h required 00000011", d);
    end
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, d, f);
    vectors++;
    if (d !== 32'h0000_1122) begin
      miscompares++;
      $display("FAIL lh_12: rdata=%h required 00001122", d);
    end
  endtask

  task automatic test_store_byte();
    logic [31:0] d;
    logic f;
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'hAAAA_AA80, d, f);
    do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, d, f);
    vectors++;
    if (d !== 32'hFFFF_FF80) begin
      miscompares++;
      $display("FAIL lb_12_sign: rdata=%h required ffffff80", d);
    end
    do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, d, f);
    vectors++;
    if (d !== 32'h0000_0080) begin
      miscompares++;
      $display("FAIL lbu_12: rdata=%h required 00000080", d);
    end
    do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, d, f);
    vectors++;
    if (d !== 32'h1180_3344) begin
      miscompares++;
      $display("FAIL lw_10_after_sb: rdata=%h required 11803344", d);
    end
    // Half store to the upper lanes, then signed and unsigned half loads
    do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234_BEEF, d, f);
    do_req(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, d, f);
    vectors++;
    if (d !== 32'hFFFF_BEEF) begin
      miscompares++;
      $display("FAIL lh_16_sign: rdata=%h required ffffbeef", d);
    end
    do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, d, f);
    vectors++;
    if (d !== 32'h0000_BEEF) begin
      miscompares++;
      $display("FAIL lhu_16: rdata=%h required 0000beef", d);
    end
  endtask

  task automatic test_fault();
    logic [31:0] d;
    logic f;
    do_req(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, d, f);
    vectors++;
    if (d !== 32'h0 || f !== 1'b1 || fault_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL lw_misaligned: rdata=%h fault=%b sticky=%b required 0/1/1",
               d, f, fault_sticky);
    end
    do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_FFFF, d, f);
    vectors++;
    if (f !== 1'b1) begin
      miscompares++;
      $display("FAIL sh_misaligned: fault=%b required 1", f);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, f);
    vectors++;
    if (d !== 32'h1180_3344 || f !== 1'b0 || fault_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL mem_after_fault: rdata=%h fault=%b sticky=%b required 11803344/0/1",
               d, f, fault_sticky);
    end
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, d, f);
    vectors++;
    if (d !== 32'h0 || f !== 1'b1) begin
      miscompares++;
      $display("FAIL size_11: rdata=%h fault=%b required 0/1", d, f);
    end
  endtask

  task automatic test_range();
    logic [31:0] d;
    logic f;
    do_req(1'b1, 2'b10, 1'b0, 32'h400, 32'hDEAD_BEEF, d, f);
    vectors++;
    if (f !== 1'b1) begin
      miscompares++;
      $display("FAIL sw_400_range: fault=%b required 1", f);
    end
    do_req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFE_F00D, d, f);
    do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, d, f);
    vectors++;
    if (d !== 32'hCAFE_F00D || f !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_3fc: rdata=%h fault=%b required cafef00d/0", d, f);
    end
`ifndef DMEM_MMIO_EN
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FF00, 32'h0, d, f);
    vectors++;
    if (f !== 1'b1 || d !== 32'h0) begin
      miscompares++;
      $display("FAIL window_no_mmio: fault=%b rdata=%h required 1/0", f, d);
    end
`endif
  endtask

  // Store then load of the same word in consecutive cycles
  task automatic test_back_to_back();
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5_5A5A);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_store_rsp: valid=%b fault=%b ready=%b required 1/0/1",
               rsp_valid, rsp_fault, req_ready);
    end
    drive(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_5A5A) begin
      miscompares++;
      $display("FAIL b2b_load: valid=%b rdata=%h required 1/a5a55a5a", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);  // waits behind the stalled response
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1180_3344 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: valid=%b rdata=%h ready=%b required 1/11803344/0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || rsp_rdata !== 32'h1180_3344) begin
      miscompares++;
      $display("FAIL bp_release: ready=%b rdata=%h required 1/11803344", req_ready, rsp_rdata);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_0044) begin
      miscompares++;
      $display("FAIL bp_next: valid=%b rdata=%h required 1/00000044", rsp_valid, rsp_rdata);
    end
  endtask

  // Reset while a response is stalled drops it and clears the sticky flag
  task automatic test_reset_drop();
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || fault_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_drop: valid=%b rdata=%h sticky=%b required 0/0/0",
               rsp_valid, rsp_rdata, fault_sticky);
    end
  endtask

`ifdef DMEM_MMIO_EN
  task automatic test_mmio();
    logic [31:0] d;
    logic f;
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FF00, 32'h0, d, f);
    vectors++;
    if (d !== 32'h0000_05A5 || f !== 1'b0) begin
      miscompares++;
      $display("FAIL mmio_gpio_in: rdata=%h fault=%b required 000005a5/0", d, f);
    end
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FF04, 32'hFFFF_FFFF, d, f);
    vectors++;
    if (gpio_out !== 21'h1F_FFFF || f !== 1'b0) begin
      miscompares++;
      $display("FAIL mmio_gpio_out: gpio_out=%h fault=%b required 1fffff/0", gpio_out, f);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FF04, 32'h0, d, f);
    vectors++;
    if (d !== 32'h001F_FFFF) begin
      miscompares++;
      $display("FAIL mmio_out_rb: rdata=%h required 001fffff", d);
    end
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FF00, 32'h1234_5678, d, f);
    vectors++;
    if (f !== 1'b0) begin
      miscompares++;
      $display("FAIL mmio_in_store: fault=%b required 0", f);
    end
    do_req(1'b0, 2'b00, 1'b0, 32'hFFFF_FF00, 32'h0, d, f);
    vectors++;
    if (f !== 1'b1 || d !== 32'h0) begin
      miscompares++;
      $display("FAIL mmio_byte: fault=%b rdata=%h required 1/0", f, d);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FF08, 32'h0, d, f);
    vectors++;
    if (f !== 1'b1) begin
      miscompares++;
      $display("FAIL mmio_bad_off: fault=%b required 1", f);
    end
    apply_reset();
    vectors++;
    if (gpio_out !== '0) begin
      miscompares++;
      $display("FAIL mmio_reset: gpio_out=%h required 0", gpio_out);
    end
  endtask
`endif

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    rsp_ready    = 1'b1;
    gpio_in      = 11'h5A5;
    test_reset();
    test_word_byte();
    test_store_byte();
    test_fault();
    test_range();
    test_back_to_back();
    test_backpressure();
    test_reset_drop();
`ifdef DMEM_MMIO_EN
    test_mmio();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Byte-addressed, byte-lane data memory for the RV32 core's MEM stage. Serves LB/LH/LW/LBU/LHU/SB/SH/SW with sign/zero extension, a registered one-cycle read, and a valid/ready request/response handshake with back-pressure. Detects misaligned and out-of-range accesses and reports them as faults. Optionally decodes a small memory-mapped I/O window for board inputs and outputs.

## Interface
- DEPTH, 256: RAM depth in 32-bit words; power of two.
- IN_W, 11: width of gpio_in; 1 to 32.
- OUT_W, 21: width of gpio_out; 1 to 32.
- MMIO_BASE, 32'hFFFF_FF00: byte base of the I/O window; 256-byte aligned.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and faults.
- req_unsigned  in  1  zero-extend the load result (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  access was misaligned, out of range, or had illegal size.
- fault_sticky  out  1  set by any fault; cleared only by rst.
- gpio_in  in  IN_W  board inputs.
- gpio_out  out  OUT_W  board outputs.

## Operation
- Request is accepted on a cycle where req_valid and req_ready are both high. req_ready = !rsp_valid || rsp_ready.
- Alignment check:
  - Half faults if addr[0] is 1.
  - Word faults if addr[1:0] is not 0.
  - Size 11 always faults.
- Range check: RAM accesses fault if the word index addr[31:2] >= DEPTH, unless the address is inside the MMIO window and MMIO is enabled.
- A faulting request performs no write and no state change other than setting fault_sticky. Its response carries rsp_fault=1 and rsp_rdata=0.
- Store writes only the selected lanes:
  - Byte: lane addr[1:0] gets wdata[7:0].
  - Half: lanes addr[1]*2 and addr[1]*2+1 get wdata[15:0].
  - Word: all four lanes.
- Load extracts the addressed byte or half, then sign-extends, or zero-extends when req_unsigned is 1. req_unsigned is ignored for word loads.
- Response state: empty or full; one response is held.
  - Accept while empty, or while full with rsp_ready high: the slot is loaded.
  - Full with rsp_ready low: rsp_valid, rsp_rdata and rsp_fault hold stable, and req_ready is low.

## Timing
- Accept in cycle N; the write takes effect at the edge ending cycle N; rsp_valid is high in cycle N+1.
- Throughput is one access per cycle while rsp_ready stays high.
- A load immediately after a store to the same word returns the new data; there is no forwarding hazard because the write completes at the edge before the read.
- Reset values:
  - rsp_valid=0, rsp_rdata=0, rsp_fault=0, fault_sticky=0, gpio_out=0.
  - req_ready is high in the first cycle after rst deasserts.
  - RAM contents are not reset.
- rst asserted mid-operation drops any held response at that edge; it is not replayed.
- gpio_in is registered every cycle. A read returns the value registered in the cycle before acceptance.

## Configuration
- DMEM_MMIO_EN defined:
  - MMIO_BASE+0x0 is GPIO_IN; read-only, zero-extended from IN_W. Stores to it are ignored and do not fault.
  - MMIO_BASE+0x4 is GPIO_OUT; read/write, low OUT_W bits.
  - Non-word MMIO accesses fault. Other offsets in the window fault.
- DMEM_MMIO_EN undefined:
  - No window decode; the window range-checks as ordinary RAM and therefore faults.
  - gpio_out is tied to 0 and gpio_in is unused.

## Structure
- Package dmem_pkg holds:
  - Size encodings SZ_B, SZ_H, SZ_W.
  - MMIO offsets OFF_GPIO_IN, OFF_GPIO_OUT.
  - The load-extract function.
- One sub-module, dmem_lane_ram: a DEPTH x 32 RAM with a 4-bit write-enable and a synchronous read.
- The top level holds decode, fault logic, the response slot and the MMIO registers.

## Test plan
- SW 0x11223344 to 0x10, then LB 0x11 and LBU 0x13 -> 0x00000033, then 0x00000011. LH 0x12 -> 0x00001122.
- SB 0x80 to 0x12, then LB 0x12 -> 0xFFFFFF80. LBU 0x12 -> 0x00000080. Bytes 0x10, 0x11 and 0x13 are unchanged.
- LW 0x02 -> rsp_fault=1, rdata=0, fault_sticky=1. A following SH 0x01 faults and leaves memory unchanged.
- SW to 0x400 with DEPTH=256 -> fault. LW 0x3FC succeeds.
- Back-pressure: hold rsp_ready=0 for 3 cycles after a load -> rsp_rdata stable and req_ready=0 throughout. The next request is accepted in the cycle rsp_ready rises.
- With DMEM_MMIO_EN and gpio_in=11'h5A5: LW MMIO_BASE -> 0x000005A5. SW 0xFFFFFFFF to MMIO_BASE+4 -> gpio_out=21'h1FFFFF. rst -> gpio_out=0.
